// File: rtl/mem_wb_stage_if.sv
// MEM -> WB handshake and payload bundle.
// master is the MEM/WB-facing driver side, slave is the stage.
interface mem_wb_stage_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              in_valid;
   logic              in_ready;
   logic              regWrite_in;
   logic              memtoReg_in;
   logic [DATA_W-1:0] dataRead_in;
   logic [DATA_W-1:0] aluRes_in;
   logic [ADDR_W-1:0] regWriteAddr_in;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic              regWrite_out;
   logic              memtoReg_out;
   logic [DATA_W-1:0] dataRead_out;
   logic [DATA_W-1:0] aluRes_out;
   logic [ADDR_W-1:0] regWriteAddr_out;
   logic [DATA_W-1:0] wbData_out;
   logic              fwd_en;

   modport master (
      output in_valid,
      output regWrite_in,
      output memtoReg_in,
      output dataRead_in,
      output aluRes_in,
      output regWriteAddr_in,
      output flush,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  regWrite_out,
      input  memtoReg_out,
      input  dataRead_out,
      input  aluRes_out,
      input  regWriteAddr_out,
      input  wbData_out,
      input  fwd_en
   );

   modport slave (
      input  in_valid,
      input  regWrite_in,
      input  memtoReg_in,
      input  dataRead_in,
      input  aluRes_in,
      input  regWriteAddr_in,
      input  flush,
      input  out_ready,
      output in_ready,
      output out_valid,
      output regWrite_out,
      output memtoReg_out,
      output dataRead_out,
      output aluRes_out,
      output regWriteAddr_out,
      output wbData_out,
      output fwd_en
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with optional two-entry skid buffer.
// Head entry feeds WB; skid entry catches one beat under back-pressure.
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int SKID   = 1
) (
   input logic           clk,
   input logic           rst,
   mem_wb_stage_if.slave bus
);

   typedef struct packed {
      logic              regWrite;
      logic              memtoReg;
      logic [DATA_W-1:0] dataRead;
      logic [DATA_W-1:0] aluRes;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   entry_t inEntry;
   entry_t head;
   entry_t skid;
   logic   headValid;
   logic   skidValid;
   logic   inReady;
   logic   xferIn;
   logic   xferOut;
   logic   regWriteOut;

   assign inEntry = '{
      regWrite: bus.regWrite_in,
      memtoReg: bus.memtoReg_in,
      dataRead: bus.dataRead_in,
      aluRes:   bus.aluRes_in,
      addr:     bus.regWriteAddr_in
   };

   // With a skid slot, ready only depends on a flop, so out_ready
   // never reaches in_ready combinationally.
   if (SKID != 0) begin : gSkidReady
      assign inReady = ~skidValid;
   end else begin : gFlowReady
      assign inReady = ~headValid | bus.out_ready;
   end

   assign xferIn  = bus.in_valid & inReady & ~bus.flush;
   assign xferOut = headValid & bus.out_ready;

   // Head/skid update: flush wins, then drain/refill, then capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head      <= '0;
         skid      <= '0;
         headValid <= 1'b0;
         skidValid <= 1'b0;
      end else if (bus.flush) begin
         headValid <= 1'b0;
         skidValid <= 1'b0;
      end else if (xferOut) begin
         if (skidValid) begin
            head      <= skid;
            skidValid <= 1'b0;
         end else if (xferIn) begin
            head <= inEntry;
         end else begin
            headValid <= 1'b0;
         end
      end else if (xferIn) begin
         if (!headValid) begin
            head      <= inEntry;
            headValid <= 1'b1;
         end else if (SKID != 0) begin
            skid      <= inEntry;
            skidValid <= 1'b1;
         end
      end
   end

   // $0 is hardwired zero, so it never counts as a write.
   assign regWriteOut = headValid & head.regWrite & (head.addr != '0);

   assign bus.in_ready         = inReady;
   assign bus.out_valid        = headValid;
   assign bus.regWrite_out     = regWriteOut;
   assign bus.memtoReg_out     = head.memtoReg;
   assign bus.dataRead_out     = head.dataRead;
   assign bus.aluRes_out       = head.aluRes;
   assign bus.regWriteAddr_out = head.addr;
   assign bus.wbData_out       = head.memtoReg ? head.dataRead
                                               : head.aluRes;
   assign bus.fwd_en           = headValid & regWriteOut;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: scoreboarded SKID=1 instance plus
// directed checks on a SKID=0 instance.
module tb_mem_wb_stage;
   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      logic          rw;
      logic          m2r;
      logic [DW-1:0] dr;
      logic [DW-1:0] alu;
      logic [AW-1:0] addr;
      logic [DW-1:0] expWb;
      logic          expRw;
   } vec_t;

   typedef struct {
      logic [DW-1:0] wb;
      logic [AW-1:0] addr;
      logic          rw;
      logic          m2r;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   nTests = 0;
   int   nFail  = 0;
   exp_t sb[$];

   mem_wb_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   mem_wb_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

   mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .SKID(1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .SKID(0)) dut0 (
      .clk(clk),
      .rst(rst),
      .bus(bus0.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rw, input logic m2r,
                               input logic [DW-1:0] dr,
                               input logic [DW-1:0] alu,
                               input logic [AW-1:0] addr,
                               input logic [DW-1:0] expWb,
                               input logic expRw);
      vec_t v;
      v.rw = rw; v.m2r = m2r; v.dr = dr; v.alu = alu;
      v.addr = addr; v.expWb = expWb; v.expRw = expRw;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      bus.in_valid        = 1'b1;
      bus.regWrite_in     = v.rw;
      bus.memtoReg_in     = v.m2r;
      bus.dataRead_in     = v.dr;
      bus.aluRes_in       = v.alu;
      bus.regWriteAddr_in = v.addr;
   endtask

   // Called just after a posedge; returns just after the accepting edge.
   task automatic send(input vec_t v);
      exp_t e;
      drive(v);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready && !bus.flush) begin
            e.wb = v.expWb; e.addr = v.addr;
            e.rw = v.expRw; e.m2r = v.m2r;
            sb.push_back(e);
            step();
            bus.in_valid = 1'b0;
            return;
         end
      end
      nTests++;
      nFail++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles expected accept");
      bus.in_valid = 1'b0;
   endtask

   // Monitor: every beat WB consumes must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            nTests++;
            nFail++;
            $display("FAIL sb_unexpected: got wbData 0x%0h expected no output",
                     bus.wbData_out);
         end else begin
            e = sb.pop_front();
            chk("sb_wbData", 64'(bus.wbData_out), 64'(e.wb));
            chk("sb_addr", 64'(bus.regWriteAddr_out), 64'(e.addr));
            chk("sb_regWrite", 64'(bus.regWrite_out), 64'(e.rw));
            chk("sb_memtoReg", 64'(bus.memtoReg_out), 64'(e.m2r));
            chk("sb_fwd_en", 64'(bus.fwd_en), 64'(e.rw));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vPass, vLoad, vZero, vA, vB, vD, vE, vF, vG, vH;
      vPass = mk(1, 0, 32'hDEADBEEF, 32'h12345678, 3, 32'h12345678, 1);
      vLoad = mk(1, 1, 32'hCAFEBABE, 32'h00000100, 7, 32'hCAFEBABE, 1);
      vZero = mk(1, 0, 32'h00000005, 32'h0000ABCD, 0, 32'h0000ABCD, 0);
      vA    = mk(1, 0, 32'h0, 32'h11, 1, 32'h11, 1);
      vB    = mk(1, 1, 32'h22, 32'h99, 2, 32'h22, 1);
      vD    = mk(0, 0, 32'h0, 32'h44, 4, 32'h44, 0);
      vE    = mk(1, 0, 32'h0, 32'h55, 5, 32'h55, 1);
      vF    = mk(1, 0, 32'h0, 32'h66, 6, 32'h66, 1);
      vG    = mk(1, 0, 32'h0, 32'h77, 9, 32'h77, 1);
      vH    = mk(1, 1, 32'h88, 32'h0, 10, 32'h88, 1);

      rst = 1'b1;
      bus.in_valid = 0; bus.regWrite_in = 0; bus.memtoReg_in = 0;
      bus.dataRead_in = 0; bus.aluRes_in = 0; bus.regWriteAddr_in = 0;
      bus.flush = 0; bus.out_ready = 1;
      bus0.in_valid = 0; bus0.regWrite_in = 0; bus0.memtoReg_in = 0;
      bus0.dataRead_in = 0; bus0.aluRes_in = 0; bus0.regWriteAddr_in = 0;
      bus0.flush = 0; bus0.out_ready = 0;

      // Reset state
      step();
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_fwd_en", 64'(bus.fwd_en), 64'(0));
      chk("rst_regWrite", 64'(bus.regWrite_out), 64'(0));
      chk("rst_memtoReg", 64'(bus.memtoReg_out), 64'(0));
      chk("rst_wbData", 64'(bus.wbData_out), 64'(0));
      chk("rst_addr", 64'(bus.regWriteAddr_out), 64'(0));
      chk("rst0_in_ready", 64'(bus0.in_ready), 64'(1));
      chk("rst0_out_valid", 64'(bus0.out_valid), 64'(0));

      // Pass-through, accepted on the first edge after reset release
      rst = 1'b0;
      send(vPass);
      @(negedge clk);
      chk("pass_out_valid", 64'(bus.out_valid), 64'(1));
      chk("pass_wbData", 64'(bus.wbData_out), 64'(32'h12345678));
      chk("pass_fwd_en", 64'(bus.fwd_en), 64'(1));
      step();

      // Load path selects dataRead
      send(vLoad);
      @(negedge clk);
      chk("load_wbData", 64'(bus.wbData_out), 64'(32'hCAFEBABE));
      step();

      // $0 destination suppresses the write
      send(vZero);
      @(negedge clk);
      chk("zero_out_valid", 64'(bus.out_valid), 64'(1));
      chk("zero_regWrite", 64'(bus.regWrite_out), 64'(0));
      chk("zero_fwd_en", 64'(bus.fwd_en), 64'(0));
      step();

      // Back-pressure fills the skid slot
      bus.out_ready = 1'b0;
      send(vA);
      send(vB);
      @(negedge clk);
      chk("bp_head", 64'(bus.wbData_out), 64'(32'h11));
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
      step();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_first", 64'(bus.wbData_out), 64'(32'h11));
      step();
      @(negedge clk);
      chk("bp_second", 64'(bus.wbData_out), 64'(32'h22));
      chk("bp_in_ready_back", 64'(bus.in_ready), 64'(1));
      step();
      @(negedge clk);
      chk("bp_drained", 64'(bus.out_valid), 64'(0));
      step();

      // Flush with full skid and a simultaneous incoming entry
      bus.out_ready = 1'b0;
      send(vD);
      send(vE);
      drive(vF);
      bus.flush = 1'b1;
      sb.delete();
      step();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
      chk("flush_in_ready", 64'(bus.in_ready), 64'(1));
      chk("flush_fwd_en", 64'(bus.fwd_en), 64'(0));
      step();
      bus.out_ready = 1'b1;
      repeat (3) step();
      chk("flush_nothing_left", 64'(bus.out_valid), 64'(0));

      // Asynchronous reset between edges
      bus.out_ready = 1'b0;
      send(vG);
      chk("ar_pre_valid", 64'(bus.out_valid), 64'(1));
      #3;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", 64'(bus.out_valid), 64'(0));
      chk("ar_wbData", 64'(bus.wbData_out), 64'(0));
      chk("ar_addr", 64'(bus.regWriteAddr_out), 64'(0));
      chk("ar_fwd_en", 64'(bus.fwd_en), 64'(0));
      sb.delete();
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      send(vH);
      @(negedge clk);
      chk("ar_first_valid", 64'(bus.out_valid), 64'(1));
      chk("ar_first_wbData", 64'(bus.wbData_out), 64'(32'h88));
      step();

      // SKID=0: in_ready follows out_ready combinationally
      bus0.out_ready = 1'b0;
      bus0.in_valid = 1'b1;
      bus0.regWrite_in = 1'b1;
      bus0.regWriteAddr_in = 5'd12;
      bus0.aluRes_in = 32'hA0A0;
      step();
      bus0.in_valid = 1'b0;
      chk("s0_out_valid", 64'(bus0.out_valid), 64'(1));
      chk("s0_wbData", 64'(bus0.wbData_out), 64'(32'hA0A0));
      chk("s0_in_ready_stall", 64'(bus0.in_ready), 64'(0));
      bus0.out_ready = 1'b1;
      #1;
      chk("s0_in_ready_go", 64'(bus0.in_ready), 64'(1));
      bus0.in_valid = 1'b1;
      bus0.aluRes_in = 32'hB1B1;
      step();
      chk("s0_next", 64'(bus0.wbData_out), 64'(32'hB1B1));
      bus0.in_valid = 1'b0;
      step();
      chk("s0_empty", 64'(bus0.out_valid), 64'(0));

      step();
      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the dataRead and aluRes payloads.
REQ-002 Parameter ADDR_W, default 5, width of the destination register address.
REQ-003 Parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  upstream (MEM) entry present this cycle.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 regWrite_in, memtoReg_in  input  1 each  control bits from MEM.
REQ-009 dataRead_in, aluRes_in  input  DATA_W each  memory read data and ALU result.
REQ-010 regWriteAddr_in  input  ADDR_W  destination register.
REQ-011 flush  input  1  discard all held and incoming entries.
REQ-012 out_valid  output  1  held entry valid toward WB.
REQ-013 out_ready  input  1  WB consumes the head entry this cycle.
REQ-014 regWrite_out, memtoReg_out  output  1 each  head-entry control bits.
REQ-015 dataRead_out, aluRes_out  output  DATA_W each  head-entry payload.
REQ-016 regWriteAddr_out  output  ADDR_W  head-entry destination.
REQ-017 wbData_out  output  DATA_W  memtoReg_out ? dataRead_out : aluRes_out.
REQ-018 fwd_en  output  1  forwarding hit qualifier: out_valid & regWrite_out.

Function
REQ-019 Transfer in occurs when in_valid & in_ready & !flush; transfer out occurs when out_valid & out_ready.
REQ-020 Head register SHALL load on a transfer in when the head is empty or is being transferred out in the same cycle; latency in->out is exactly 1 cycle.
REQ-021 SKID=1: a transfer in while the head is valid and out_ready=0 SHALL be stored in the skid entry.
REQ-022 SKID=1: when the skid entry is full and the head transfers out, the skid entry SHALL move to the head in that cycle and the skid entry SHALL become empty.
REQ-023 SKID=1: in_ready SHALL be the registered negation of skid-full; no combinational path from out_ready to in_ready.
REQ-024 SKID=0: in_ready SHALL equal !out_valid | out_ready.
REQ-025 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush.
REQ-026 regWrite_out SHALL be 0 whenever out_valid=0 or regWriteAddr_out=0 (register $0 never written).
REQ-027 flush SHALL clear head and skid valid bits at the next edge, override any simultaneous transfer in or out, and deassert out_valid/fwd_en from the following cycle.
REQ-028 Payload fields of an invalidated entry MAY hold stale data; control outputs SHALL obey REQ-026.
REQ-029 Head not valid and out_ready=1 SHALL cause no state change.

Reset
REQ-030 While rst=1, out_valid, regWrite_out, memtoReg_out, fwd_en SHALL be 0, all data/address outputs 0, skid entry empty.
REQ-031 in_ready SHALL be 1 during reset for SKID=1, and 1 during reset for SKID=0 since out_valid=0.
REQ-032 Reset asserted mid-operation SHALL discard both entries immediately, without waiting for clk.
REQ-033 First transfer in SHALL be accepted on the first posedge after rst deasserts.

Verification
REQ-034 Pass-through: out_ready=1, in_valid=1, aluRes_in=0x12345678, addr=3, regWrite=1, memtoReg=0 -> next cycle out_valid=1, wbData_out=0x12345678, fwd_en=1.
REQ-035 Back-pressure SKID=1: out_ready=0, send A=0x11 then B=0x22 -> head=A, in_ready=0 after B; raise out_ready -> A, then B on consecutive cycles.
REQ-036 $0 suppression: regWrite_in=1, regWriteAddr_in=0 -> regWrite_out=0, fwd_en=0, out_valid=1.
REQ-037 Flush with full skid, in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, incoming entry never appears.
REQ-038 Async reset: assert rst between edges with head valid -> out_valid=0 and data outputs 0 before the next posedge.
REQ-039 SKID=0 regression: out_ready held 0 with head valid -> in_ready=0 combinationally; out_ready=1 -> in_ready=1 in the same cycle.
